// File: rtl/reward_pkg.sv
// Shared definitions for the reward scanner.
// Holds the scan FSM state type, the number of words per neighbour-table entry,
// the not-found reward pattern and the saturating-add helper.
// Build option: REWARD_SCAN_ENERGY_EN adds a fourth residual_energy word per entry.
package reward_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdCnt,
        StCapCnt,
        StRdW,
        StCapW,
        StEval,
        StDone
    } scan_state_e;

`ifdef REWARD_SCAN_ENERGY_EN
    localparam int unsigned WPE = 4;
`else
    localparam int unsigned WPE = 3;
`endif

    // Word index within an entry never exceeds 3.
    localparam int unsigned WORD_IDX_W = 2;

    // Top WORD_WIDTH bits of this give the most-negative value at any width.
    localparam logic [63:0] NOT_FOUND_MSB = 64'h8000_0000_0000_0000;

    // Adds two terms and clamps the result symmetrically to [-lim, lim].
    function automatic int sat_add(input int a, input int b, input int lim);
        int s;
        s = a + b;
        if (s > lim) begin
            return lim;
        end
        if (s < -lim) begin
            return -lim;
        end
        return s;
    endfunction

endpackage

// File: rtl/reward_calc.sv
// Combinational reward arithmetic for a located table entry.
// Ports: action/besthop select the best-hop bonus, cluster_id/my_cluster_id the
// cluster bonus, hop_count is subtracted; reward is the saturated signed result.
// With REWARD_SCAN_ENERGY_EN an energy input contributes energy>>4.
module reward_calc
    import reward_pkg::*;
#(
    parameter int unsigned WORD_WIDTH    = 16,
    parameter int          BEST_BONUS    = 100,
    parameter int          CLUSTER_BONUS = 50
) (
    input  logic [WORD_WIDTH-1:0] action,
    input  logic [WORD_WIDTH-1:0] besthop,
    input  logic [WORD_WIDTH-1:0] cluster_id,
    input  logic [WORD_WIDTH-1:0] my_cluster_id,
    input  logic [WORD_WIDTH-1:0] hop_count,
`ifdef REWARD_SCAN_ENERGY_EN
    input  logic [WORD_WIDTH-1:0] energy,
`endif
    output logic [WORD_WIDTH-1:0] reward
);

    localparam int unsigned SW  = WORD_WIDTH + 2;
    // Symmetric limit keeps the most-negative code free for "not found".
    localparam int          LIM = int'((64'd1 << (WORD_WIDTH - 1)) - 64'd1);

    logic signed [SW-1:0] bonus;
    logic signed [SW-1:0] penalty;
    int                   sum_sat;

    always_comb begin
        bonus = '0;
        if (action == besthop) begin
            bonus = bonus + SW'(BEST_BONUS);
        end
        if (cluster_id == my_cluster_id) begin
            bonus = bonus + SW'(CLUSTER_BONUS);
        end
`ifdef REWARD_SCAN_ENERGY_EN
        bonus = bonus + SW'({4'b0000, energy[WORD_WIDTH-1:4]});
`endif
        penalty = SW'(hop_count);
        sum_sat = sat_add(int'(bonus), -int'(penalty), LIM);
        reward  = sum_sat[WORD_WIDTH-1:0];
    end

endmodule

// File: rtl/reward_scan.sv
// Neighbour-table scanner: reads a count word then WPE-word entries from a
// one-cycle-latency memory, looks for the entry whose node_id equals the latched
// action and reports a saturated signed reward.
// Ports: clock, reset (sync, active-high); start/action/besthop/my_cluster_id
// request; mem_addr/mem_data memory read port; busy, done (1-cycle pulse),
// found, reward results.
// Build option: REWARD_SCAN_ENERGY_EN (4-word entries with residual energy).
module reward_scan
    import reward_pkg::*;
#(
    parameter int unsigned WORD_WIDTH    = 16,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned MAX_NEIGHBORS = 8,
    parameter int unsigned TABLE_BASE    = 0,
    parameter int          BEST_BONUS    = 100,
    parameter int          CLUSTER_BONUS = 50
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] action,
    input  logic [WORD_WIDTH-1:0] besthop,
    input  logic [WORD_WIDTH-1:0] my_cluster_id,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [WORD_WIDTH-1:0] reward
);

    localparam int unsigned CW = $clog2(MAX_NEIGHBORS + 1);
    localparam logic [WORD_WIDTH-1:0] NOT_FOUND = NOT_FOUND_MSB[63 -: WORD_WIDTH];

    scan_state_e state_q, state_d;
    logic [WORD_WIDTH-1:0] action_q, action_d, besthop_q, besthop_d, mycl_q, mycl_d;
    logic [WORD_WIDTH-1:0] node_q, node_d, clus_q, clus_d, hop_q, hop_d;
    logic [CW-1:0]         count_q, count_d, entry_q, entry_d, cnt_clamp;
    logic [WORD_IDX_W-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  hit_q, hit_d, found_q, found_d;
    logic [WORD_WIDTH-1:0] reward_q, reward_d, calc_reward;
`ifdef REWARD_SCAN_ENERGY_EN
    logic [WORD_WIDTH-1:0] energy_q, energy_d;
`endif

    reward_calc #(
        .WORD_WIDTH   (WORD_WIDTH),
        .BEST_BONUS   (BEST_BONUS),
        .CLUSTER_BONUS(CLUSTER_BONUS)
    ) u_calc (
        .action       (action_q),
        .besthop      (besthop_q),
        .cluster_id   (clus_q),
        .my_cluster_id(mycl_q),
        .hop_count    (hop_q),
`ifdef REWARD_SCAN_ENERGY_EN
        .energy       (energy_q),
`endif
        .reward       (calc_reward)
    );

    always_comb begin
        if (mem_data > WORD_WIDTH'(MAX_NEIGHBORS)) begin
            cnt_clamp = CW'(MAX_NEIGHBORS);
        end else begin
            cnt_clamp = mem_data[CW-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        action_d  = action_q;
        besthop_d = besthop_q;
        mycl_d    = mycl_q;
        node_d    = node_q;
        clus_d    = clus_q;
        hop_d     = hop_q;
        count_d   = count_q;
        entry_d   = entry_q;
        word_d    = word_q;
        addr_d    = addr_q;
        hit_d     = hit_q;
        found_d   = found_q;
        reward_d  = reward_q;
`ifdef REWARD_SCAN_ENERGY_EN
        energy_d  = energy_q;
`endif
        done      = 1'b0;
        busy      = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRdCnt;
                    action_d  = action;
                    besthop_d = besthop;
                    mycl_d    = my_cluster_id;
                    addr_d    = ADDR_WIDTH'(TABLE_BASE);
                    entry_d   = '0;
                    word_d    = '0;
                    hit_d     = 1'b0;
                end
            end
            StRdCnt: state_d = StCapCnt;
            StCapCnt: begin
                count_d = cnt_clamp;
                if (cnt_clamp == '0) begin
                    state_d = StEval;
                end else begin
                    state_d = StRdW;
                    addr_d  = ADDR_WIDTH'(TABLE_BASE + 1);
                end
            end
            StRdW: state_d = StCapW;
            StCapW: begin
                case (word_q)
                    2'd0:    node_d = mem_data;
                    2'd1:    clus_d = mem_data;
                    2'd2:    hop_d  = mem_data;
`ifdef REWARD_SCAN_ENERGY_EN
                    2'd3:    energy_d = mem_data;
`endif
                    default: ;
                endcase
                if (word_q == WORD_IDX_W'(WPE - 1)) begin
                    // node_id was captured on word 0 of this same entry.
                    if (node_q == action_q) begin
                        hit_d   = 1'b1;
                        state_d = StEval;
                    end else if (entry_q == CW'(count_q - 1'b1)) begin
                        state_d = StEval;
                    end else begin
                        entry_d = entry_q + 1'b1;
                        word_d  = '0;
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = StRdW;
                    end
                end else begin
                    word_d  = word_q + 1'b1;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = StRdW;
                end
            end
            StEval: begin
                found_d  = hit_q;
                reward_d = hit_q ? calc_reward : NOT_FOUND;
                state_d  = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            action_q  <= '0;
            besthop_q <= '0;
            mycl_q    <= '0;
            node_q    <= '0;
            clus_q    <= '0;
            hop_q     <= '0;
            count_q   <= '0;
            entry_q   <= '0;
            word_q    <= '0;
            addr_q    <= '0;
            hit_q     <= 1'b0;
            found_q   <= 1'b0;
            reward_q  <= '0;
`ifdef REWARD_SCAN_ENERGY_EN
            energy_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            action_q  <= action_d;
            besthop_q <= besthop_d;
            mycl_q    <= mycl_d;
            node_q    <= node_d;
            clus_q    <= clus_d;
            hop_q     <= hop_d;
            count_q   <= count_d;
            entry_q   <= entry_d;
            word_q    <= word_d;
            addr_q    <= addr_d;
            hit_q     <= hit_d;
            found_q   <= found_d;
            reward_q  <= reward_d;
`ifdef REWARD_SCAN_ENERGY_EN
            energy_q  <= energy_d;
`endif
        end
    end

    assign mem_addr = addr_q;
    assign found    = found_q;
    assign reward   = reward_q;

endmodule
